// File: rtl/seqdet_arbiter.sv
// seqdet_arbiter: round-robin word arbiter feeding a shared overlapping Mealy 1001 detector.
// Define SEQDET_CARRY_EN to keep per-requester detector state so matches span consecutive words.
module seqdet_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int WORD_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WORD_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [CNT_W-1:0]         rsp_count,
  output logic                     rsp_hit,
  output logic                     busy
);
  localparam int BW = $clog2(WORD_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;
  state_t state;
  det_t det, det_nxt;
  logic [WORD_W-1:0] sh, word;
  logic [BW-1:0] bit_cnt;
  logic [IDW-1:0] rr_ptr, g, c;
  logic found, msb, match, last;
  logic [CNT_W-1:0] cnt_nxt;
`ifdef SEQDET_CARRY_EN
  det_t saved [NREQ];
`endif
  always_comb begin
    found = 1'b0;
    g = '0;
    c = '0;
    for (int k = 1; k <= NREQ; k++) begin
      c = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[c]) begin
        found = 1'b1;
        g = c;
      end
    end
  end
  always_comb begin
    word = '0;
    for (int i = 0; i < NREQ; i++)
      if (g == IDW'(i)) word = req_data[i*WORD_W +: WORD_W];
  end
  always_comb begin
    msb = sh[WORD_W-1];
    match = msb && det == S3;
    det_nxt = msb ? S1 : det == S1 ? S2 : det == S2 ? S3 : S0;
    cnt_nxt = (match && rsp_count != '1) ? rsp_count + 1'b1 : rsp_count;
    last = bit_cnt == BW'(WORD_W - 1);
  end
  // Grant is gated by rstn so nothing looks accepted while reset is held.
  assign req_ready = (rstn && state == IDLE && found) ? NREQ'(1) << g : '0;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      det <= S0;
      sh <= '0;
      bit_cnt <= '0;
      rr_ptr <= IDW'(NREQ - 1);
      rsp_id <= '0;
      rsp_count <= '0;
      rsp_hit <= 1'b0;
`ifdef SEQDET_CARRY_EN
      for (int i = 0; i < NREQ; i++) saved[i] <= S0;
`endif
    end else begin
      case (state)
        IDLE: if (found) begin
          sh <= word;
          rsp_id <= g;
          rr_ptr <= g;
          rsp_count <= '0;
          rsp_hit <= 1'b0;
          bit_cnt <= '0;
`ifdef SEQDET_CARRY_EN
          det <= saved[g];
`else
          det <= S0;
`endif
          state <= SHIFT;
        end
        SHIFT: begin
          det <= det_nxt;
          sh <= sh << 1;
          bit_cnt <= bit_cnt + 1'b1;
          rsp_count <= cnt_nxt;
          if (last) begin
            rsp_hit <= |cnt_nxt;
            state <= RESP;
`ifdef SEQDET_CARRY_EN
            saved[rsp_id] <= det_nxt;
`endif
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
